fifo_rd_stream: RTL

Read-side consumer stage placed directly downstream of the dual-clock FIFO memory, in the rclk domain. It watches the FIFO empty flag and the combinational read data, and issues r_en to pop words into a 2-entry output buffer. It presents those words on a valid/ready stream. All stream outputs are registered, and r_en has no combinational dependence on m_ready.

---
 rtl/fifo_rd_stream_pkg.sv | 13 +
 rtl/fifo_rd_stream_if.sv | 16 +
 rtl/fifo_rd_stream_skid.sv | 84 ++++++++
 rtl/fifo_rd_stream.sv | 66 ++++++
 4 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// Shared types for the FIFO read-side stream stage: buffer occupancy states and depth.
package fifo_rd_pkg;

  localparam int BUF_DEPTH = 2;
  localparam int LEVEL_W   = 2;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } occ_state_e;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Valid/ready output stream of the FIFO read stage, with buffer occupancy alongside.
interface fifo_rd_stream_if
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8
);

  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic [LEVEL_W-1:0]    m_level;

  modport master (output m_valid, m_data, m_level, input m_ready);
  modport slave  (input m_valid, m_data, m_level, output m_ready);

endinterface

// File: rtl/fifo_rd_stream_skid.sv
// Two-entry output buffer (head/tail) whose state is its occupancy; head is always the
// word on the stream, tail only holds the second word captured under backpressure.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  m_ready,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [LEVEL_W-1:0]    m_level,
  output occ_state_e            state
);

  occ_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic                  valid_q, valid_d;
  logic                  pop;

  assign pop = valid_q && m_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d = S0;
    end else begin
      case (state_q)
        S0: begin
          if (push) begin
            state_d = S1;
            head_d  = wdata;
          end
        end
        S1: begin
          if (push && pop) begin
            head_d = wdata;
          end else if (push) begin
            state_d = S2;
            tail_d  = wdata;
          end else if (pop) begin
            state_d = S0;
          end
        end
        S2: begin
          // push is impossible here because r_en is gated off in S2
          if (pop) begin
            state_d = S1;
            head_d  = tail_q;
          end
        end
        default: state_d = S0;
      endcase
    end
    valid_d = (state_d != S0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S0;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
    end
  end

  assign m_valid = valid_q;
  assign m_data  = head_q;
  assign m_level = state_q;
  assign state   = state_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side consumer of the dual-clock FIFO: pops words into a 2-entry buffer and streams them.
// Optional saturating delivered-word counter (pop_count) enabled by FIFO_RD_STREAM_CNT_EN.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  r_en,
  input  logic                  flush,
  fifo_rd_stream_if.master      m_if
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  pop_count
`endif
);

  occ_state_e state;

  // r_en never looks at m_ready, so a full buffer simply stops popping
  assign r_en = rrst_n && !empty && !flush && (state != S2);

  fifo_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk     (rclk),
    .rst_n   (rrst_n),
    .flush   (flush),
    .push    (r_en),
    .wdata   (fifo_rdata),
    .m_ready (m_if.m_ready),
    .m_valid (m_if.m_valid),
    .m_data  (m_if.m_data),
    .m_level (m_if.m_level),
    .state   (state)
  );

`ifdef FIFO_RD_STREAM_CNT_EN
  logic                 pop;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  assign pop = m_if.m_valid && m_if.m_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (pop && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pop_count = cnt_q;
`endif

endmodule
